icw_receiver: RTL and testbench

ICW_RECEIVER -- requirements
Module: icw_receiver

---
 rtl/icw_receiver_pkg.sv | 30 +++
 rtl/icw_receiver.sv | 136 +++++++++++++
 tb/tb_icw_receiver.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/icw_receiver_pkg.sv
// Shared definitions for the ICW receiver: FSM state codes and ICW1/ICW4
// bit positions, plus a small decode helper.
package icw_receiver_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_ICW2 = 3'd1;
  localparam state_t ST_WAIT_ICW3 = 3'd2;
  localparam state_t ST_WAIT_ICW4 = 3'd3;
  localparam state_t ST_READY     = 3'd4;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_ADI  = 2;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_FLAG = 4;

  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  // ICW1 is recognised purely by address and the flag bit, independent of state.
  function automatic logic is_icw1(input logic a0, input logic [7:0] din);
    return !a0 && din[ICW1_FLAG];
  endfunction

endpackage

// File: rtl/icw_receiver.sv
// Initialization command word receiver: walks the ICW1..ICW4 sequence,
// latches configuration fields and forwards post-init writes as OCW strobes.
module icw_receiver
  import icw_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       sp,
  output logic       ltim,
  output logic       adi,
  output logic       sngl,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_map,
  output logic [2:0] slave_id,
  output logic       upm,
  output logic       aeoi,
  output logic       ms,
  output logic       buf_en,
  output logic       sfnm,
  output logic       init_done,
  output logic       ocw_wr,
  output logic       ocw_a0,
  output logic [7:0] ocw_data,
  output logic       seq_err
);

  state_t state_reg;
  logic   icw1_wr;

  assign icw1_wr = wr_en && is_icw1(a0, din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ltim        <= 1'b0;
      adi         <= 1'b0;
      sngl        <= 1'b0;
      ic4         <= 1'b0;
      vector_base <= '0;
      cascade_map <= '0;
      slave_id    <= '0;
      upm         <= 1'b0;
      aeoi        <= 1'b0;
      ms          <= 1'b0;
      buf_en      <= 1'b0;
      sfnm        <= 1'b0;
      init_done   <= 1'b0;
      ocw_wr      <= 1'b0;
      ocw_a0      <= 1'b0;
      ocw_data    <= '0;
      seq_err     <= 1'b0;
    end else begin
      ocw_wr  <= 1'b0;
      seq_err <= 1'b0;
      if (icw1_wr) begin
        // ICW1 always restarts the sequence and wipes the previous configuration
        ltim        <= din[ICW1_LTIM];
        adi         <= din[ICW1_ADI];
        sngl        <= din[ICW1_SNGL];
        ic4         <= din[ICW1_IC4];
        vector_base <= '0;
        cascade_map <= '0;
        slave_id    <= '0;
        upm         <= 1'b0;
        aeoi        <= 1'b0;
        ms          <= 1'b0;
        buf_en      <= 1'b0;
        sfnm        <= 1'b0;
        init_done   <= 1'b0;
        state_reg   <= ST_WAIT_ICW2;
      end else if (wr_en) begin
        case (state_reg)
          ST_WAIT_ICW2: begin
            if (a0) begin
              vector_base <= din[7:3];
              if (!sngl) begin
                state_reg <= ST_WAIT_ICW3;
              end else if (ic4) begin
                state_reg <= ST_WAIT_ICW4;
              end else begin
                state_reg <= ST_READY;
                init_done <= 1'b1;
              end
            end else begin
              seq_err <= 1'b1;
            end
          end
          ST_WAIT_ICW3: begin
            if (a0) begin
              // sp decides whether this word is a slave map or our own id
              if (sp) begin
                cascade_map <= din;
              end else begin
                slave_id <= din[2:0];
              end
              if (ic4) begin
                state_reg <= ST_WAIT_ICW4;
              end else begin
                state_reg <= ST_READY;
                init_done <= 1'b1;
              end
            end else begin
              seq_err <= 1'b1;
            end
          end
          ST_WAIT_ICW4: begin
            if (a0) begin
              upm       <= din[ICW4_UPM];
              aeoi      <= din[ICW4_AEOI];
              ms        <= din[ICW4_MS];
              buf_en    <= din[ICW4_BUF];
              sfnm      <= din[ICW4_SFNM];
              state_reg <= ST_READY;
              init_done <= 1'b1;
            end else begin
              seq_err <= 1'b1;
            end
          end
          ST_READY: begin
            ocw_wr   <= 1'b1;
            ocw_a0   <= a0;
            ocw_data <= din;
          end
          default: begin
            state_reg <= state_reg;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icw_receiver.sv
// Scoreboard bench for icw_receiver: a queue-based reference model predicts
// the full output snapshot after each cycle, a monitor compares it.
module tb_icw_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       sp = 1'b0;
  logic       ltim, adi, sngl, ic4;
  logic [4:0] vector_base;
  logic [7:0] cascade_map;
  logic [2:0] slave_id;
  logic       upm, aeoi, ms, buf_en, sfnm;
  logic       init_done, ocw_wr, ocw_a0, seq_err;
  logic [7:0] ocw_data;

  always #5 clk = ~clk;

  icw_receiver dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .a0(a0), .din(din), .sp(sp),
    .ltim(ltim), .adi(adi), .sngl(sngl), .ic4(ic4),
    .vector_base(vector_base), .cascade_map(cascade_map), .slave_id(slave_id),
    .upm(upm), .aeoi(aeoi), .ms(ms), .buf_en(buf_en), .sfnm(sfnm),
    .init_done(init_done), .ocw_wr(ocw_wr), .ocw_a0(ocw_a0),
    .ocw_data(ocw_data), .seq_err(seq_err)
  );

  int checks = 0;
  int passed = 0;
  int txn = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp, mon_got;

  // Reference model: raw command bytes plus a list of ICWs still owed.
  logic [7:0] m_icw1, m_icw2, m_icw3, m_icw4, m_ocw_data;
  logic       m_master, m_active, m_ocw_wr, m_ocw_a0, m_seq_err;
  int         pending[$];

  function automatic void model_reset();
    m_icw1 = 0; m_icw2 = 0; m_icw3 = 0; m_icw4 = 0; m_ocw_data = 0;
    m_master = 0; m_active = 0; m_ocw_wr = 0; m_ocw_a0 = 0; m_seq_err = 0;
    pending.delete();
  endfunction

  function automatic void model_step(input logic w, input logic a, input logic [7:0] d, input logic s);
    int k;
    m_ocw_wr  = 0;
    m_seq_err = 0;
    if (!w) return;
    if (!a && d[4]) begin
      m_icw1 = d; m_icw2 = 0; m_icw3 = 0; m_icw4 = 0; m_master = 0;
      pending.delete();
      pending.push_back(2);
      if (!d[1]) pending.push_back(3);
      if (d[0]) pending.push_back(4);
      m_active = 1;
    end else if (!m_active) begin
      // unconfigured: ignore silently
    end else if (pending.size() == 0) begin
      m_ocw_wr = 1; m_ocw_a0 = a; m_ocw_data = d;
    end else if (!a) begin
      m_seq_err = 1;
    end else begin
      k = pending.pop_front();
      case (k)
        2: m_icw2 = d;
        3: begin m_icw3 = d; m_master = s; end
        default: m_icw4 = d;
      endcase
    end
  endfunction

  function automatic logic [36:0] model_out();
    logic ready;
    ready = m_active && (pending.size() == 0);
    return {m_icw1[3], m_icw1[2], m_icw1[1], m_icw1[0], m_icw2[7:3],
            (m_master ? m_icw3 : 8'h00), (m_master ? 3'b000 : m_icw3[2:0]),
            m_icw4[0], m_icw4[1], m_icw4[2], m_icw4[3], m_icw4[4],
            ready, m_ocw_wr, m_ocw_a0, m_ocw_data, m_seq_err};
  endfunction

  function automatic logic [36:0] dut_out();
    return {ltim, adi, sngl, ic4, vector_base, cascade_map, slave_id,
            upm, aeoi, ms, buf_en, sfnm, init_done, ocw_wr, ocw_a0, ocw_data, seq_err};
  endfunction

  task automatic drive(input logic w, input logic a, input logic [7:0] d, input logic s);
    @(negedge clk);
    wr_en = w; a0 = a; din = d; sp = s;
    model_step(w, a, d, s);
    exp_q.push_back(model_out());
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_en = 0;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (dut_out() === 37'd0) passed++;
    else $display("FAIL reset_outputs: got %h expected 0", dut_out());
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Monitor: one comparison per driven cycle, shortly after the sampling edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = dut_out();
      txn++;
      checks++;
      if (mon_got === mon_exp) begin
        passed++;
        $display("txn %0d ok out=%h", txn, mon_got);
      end else begin
        $display("FAIL txn %0d: got %h expected %h", txn, mon_got, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_out() === 37'd0) passed++;
    else $display("FAIL initial_reset: got %h expected 0", dut_out());
    @(negedge clk);
    rst_n = 1;

    // Single, no ICW4, then an OCW forward
    drive(1, 0, 8'h12, 0);
    drive(1, 1, 8'h40, 0);
    drive(0, 0, 8'h00, 0);
    chk("single_init_done", {7'd0, init_done}, 8'd1);
    chk("single_vector_base", {3'd0, vector_base}, 8'h08);
    chk("single_sngl_ltim", {6'd0, sngl, ltim}, 8'b10);
    drive(1, 1, 8'hFE, 0);
    drive(0, 0, 8'h00, 0);
    chk("ocw_pulse", {7'd0, ocw_wr}, 8'd1);
    chk("ocw_data", ocw_data, 8'hFE);
    drive(0, 0, 8'h00, 0);
    chk("ocw_pulse_end", {7'd0, ocw_wr}, 8'd0);

    // Cascade master with ICW4
    drive(1, 0, 8'h11, 1);
    drive(1, 1, 8'h20, 1);
    drive(1, 1, 8'h0F, 1);
    drive(0, 0, 8'h00, 1);
    chk("master_not_done", {7'd0, init_done}, 8'd0);
    drive(1, 1, 8'h03, 1);
    drive(0, 0, 8'h00, 1);
    chk("master_cascade_map", cascade_map, 8'h0F);
    chk("master_upm_aeoi_done", {5'd0, upm, aeoi, init_done}, 8'b111);

    // Cascade slave
    drive(1, 0, 8'h11, 0);
    drive(1, 1, 8'h20, 0);
    drive(1, 1, 8'hFA, 0);
    drive(1, 1, 8'h01, 0);
    drive(0, 0, 8'h00, 0);
    chk("slave_id", {5'd0, slave_id}, 8'h02);
    chk("slave_cascade_map", cascade_map, 8'h00);

    // Restart mid-sequence, then an ignored write in WAIT_ICW2
    drive(1, 0, 8'h11, 0);
    drive(1, 1, 8'h20, 0);
    drive(1, 0, 8'h1A, 0);
    drive(0, 0, 8'h00, 0);
    chk("restart_fields", {3'd0, vector_base}, 8'h00);
    chk("restart_sngl_ic4_done", {5'd0, sngl, ic4, init_done}, 8'b100);
    drive(1, 0, 8'h0B, 0);
    drive(0, 0, 8'h00, 0);
    chk("seq_err_pulse", {6'd0, seq_err, ocw_wr}, 8'b10);
    drive(1, 1, 8'h48, 0);
    drive(0, 0, 8'h00, 0);
    chk("held_then_icw2", {2'd0, vector_base, seq_err, init_done}, {2'd0, 5'd9, 1'b0, 1'b1});

    // Reset in WAIT_ICW3, then a write that must be ignored
    drive(1, 0, 8'h11, 0);
    drive(1, 1, 8'h20, 0);
    drive(0, 0, 8'h00, 0);
    do_reset();
    drive(1, 1, 8'h55, 0);
    drive(0, 0, 8'h00, 0);
    chk("post_reset_ignored", {init_done, ocw_wr, seq_err, vector_base}, 8'h00);

    // Randomized traffic with occasional mid-stream resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
              8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
      end
    end
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    wr_en = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
